// File: rtl/sevenseg_pkg.sv
// Shared types and default geometry for the seven-segment digit scanner.
package sevenseg_pkg;

    typedef logic [3:0] nibble_t;

    localparam int DEFAULT_NDIGITS     = 4;
    localparam int DEFAULT_REFRESH_DIV = 50000;

endpackage

// File: rtl/refresh_tick.sv
// Prescaler: counts 0..DIV-1 and flags the last count as the digit refresh tick.
module refresh_tick #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Explicit wrap so non-power-of-two dividers keep exact period.
    always_ff @(posedge clk) begin
        if (reset)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed digit scanner feeding a seven-segment decoder; new values
// take effect only at frame boundaries. Define SEVENSEG_SCAN_BLANK_EN for leading-zero blanking.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NDIGITS     = DEFAULT_NDIGITS,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    output logic [3:0]             num,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame,
    output logic                   pending
);

    localparam int IW = $clog2(NDIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

    logic                        tick;
    logic                        boundary;
    logic [IW-1:0]               idx;
    logic [4*NDIGITS-1:0]        shadow;
    logic [4*NDIGITS-1:0]        display;
    logic [NDIGITS-1:0][3:0]     digs;
    logic [NDIGITS-1:0]          sel;
    logic [NDIGITS-1:0]          blank;
    nibble_t                     cur;

    refresh_tick #(.DIV(REFRESH_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign boundary = tick && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
            frame   <= 1'b0;
        end else begin
            frame <= boundary;
            if (load && boundary) begin
                display <= value;
                shadow  <= value;
                pending <= 1'b0;
            end else if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end else if (boundary && pending) begin
                display <= shadow;
                pending <= 1'b0;
            end
        end
    end

    assign digs = display;
    assign cur  = digs[idx];
    assign num  = cur;
    assign sel  = NDIGITS'(1) << idx;

`ifdef SEVENSEG_SCAN_BLANK_EN
    // Digit i is dark when it and every more-significant nibble are zero; digit 0 always lit.
    always_comb begin
        logic allz;
        blank = '0;
        allz  = 1'b1;
        for (int i = NDIGITS - 1; i > 0; i--) begin
            allz     = allz && (digs[i] == 4'd0);
            blank[i] = allz;
        end
    end
`else
    assign blank = '0;
`endif

    assign an = ~sel | blank;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan (NDIGITS=4, REFRESH_DIV=4) using a timeline-based scoreboard.
module tb_sevenseg_scan;

    localparam int N = 4;
    localparam int D = 4;
    localparam int F = N * D;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  num;
    logic [3:0]  an;
    logic        frame;
    logic        pending;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] num;
        logic       frame;
        logic       pend;
    } exp_t;

    exp_t q[$];

    // Reference state: position within the frame plus value registers.
    int          p;
    logic [15:0] m_disp, m_shad;
    logic        m_pend, m_frm;

    sevenseg_scan #(.NDIGITS(N), .REFRESH_DIV(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .value   (value),
        .num     (num),
        .an      (an),
        .frame   (frame),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t p=%0d)", tag, got, exp, $time, p);
        end
    endtask

    function automatic exp_t outs();
        exp_t e;
        int   dig;
        dig   = p / D;
        e.an  = ~(4'b0001 << dig);
`ifdef SEVENSEG_SCAN_BLANK_EN
        for (int i = 1; i < N; i++)
            if ((m_disp >> (4 * i)) == 16'd0) e.an[i] = 1'b1;
`endif
        e.num   = 4'((m_disp >> (4 * dig)) & 16'hF);
        e.frame = m_frm;
        e.pend  = m_pend;
        return e;
    endfunction

    task automatic compare();
        exp_t e;
        if (q.size() == 0) begin
            chk("queue_empty", 16'd1, 16'd0);
            return;
        end
        e = q.pop_front();
        chk("an",      16'(an),      16'(e.an));
        chk("num",     16'(num),     16'(e.num));
        chk("frame",   16'(frame),   16'(e.frame));
        chk("pending", 16'(pending), 16'(e.pend));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        p = 0; m_disp = 16'h0; m_shad = 16'h0; m_pend = 1'b0; m_frm = 1'b0;
        q.push_back(outs());
        @(posedge clk); #1;
        reset = 1'b0;
        compare();
    endtask

    task automatic step(input logic ld, input logic [15:0] v);
        logic bnd;
        bnd   = (p == F - 1);
        load  = ld;
        value = v;
        if (ld && bnd) begin
            m_disp = v; m_shad = v; m_pend = 1'b0;
        end else if (ld) begin
            m_shad = v; m_pend = 1'b1;
        end else if (bnd && m_pend) begin
            m_disp = m_shad; m_pend = 1'b0;
        end
        m_frm = bnd;
        p     = (p + 1) % F;
        q.push_back(outs());
        @(posedge clk); #1;
        load = 1'b0;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    task automatic seek(input int target);
        int budget;
        budget = 2 * F;
        while (p != target && budget > 0) begin
            step(1'b0, 16'h0);
            budget--;
        end
        if (p != target) chk("seek_timeout", 16'(p), 16'(target));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Free-running scan with zero display, one full frame plus wrap.
        idle(F + 2);

        // Mid-frame load is held until the boundary.
        seek(5);
        step(1'b1, 16'h1234);
        idle(F + F);

        // Last write before the boundary wins.
        seek(3);
        step(1'b1, 16'hAAAA);
        idle(4);
        step(1'b1, 16'h5678);
        idle(F + F);

        // Load on the boundary cycle applies directly.
        seek(F - 1);
        step(1'b1, 16'h00F0);
        idle(F + 2);

        // Reset during digit 2 with a value pending discards the shadow.
        seek(8);
        step(1'b1, 16'h9999);
        idle(1);
        do_reset();
        idle(F + F);

        // Leading-zero cases (blanked when the macro is defined).
        step(1'b1, 16'h0070);
        idle(F + F);
        step(1'b1, 16'h0000);
        idle(F + F);
        seek(F - 1);
        step(1'b1, 16'hF00D);
        idle(F + 2);

        if (q.size() != 0) chk("queue_left", 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
